// File: rtl/paula_audio_mix_sequencer.sv
// Paula-style audio mixer sequencer: snapshots four 8-bit channel samples and
// 7-bit volumes, then walks one shared signed-by-unsigned multiplier across
// the channels on successive 7 MHz enables, accumulating left (ch1+ch2) and
// right (ch0+ch3) sums that are published with a one-clk sum_valid pulse.
module paula_audio_mix_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic        sample_strb,
  input  logic [7:0]  sample0,
  input  logic [7:0]  sample1,
  input  logic [7:0]  sample2,
  input  logic [7:0]  sample3,
  input  logic [6:0]  vol0,
  input  logic [6:0]  vol1,
  input  logic [6:0]  vol2,
  input  logic [6:0]  vol3,
  output logic [14:0] ldatasum,
  output logic [14:0] rdatasum,
  output logic        sum_valid,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CH0  = 3'd1,
    CH1  = 3'd2,
    CH2  = 3'd3,
    CH3  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [3:0][7:0]   smp_q, smp_d;
  logic [3:0][6:0]   vol_q, vol_d;
  logic [14:0]       lacc_q, lacc_d;
  logic [14:0]       racc_q, racc_d;
  logic [14:0]       lsum_q, lsum_d;
  logic [14:0]       rsum_q, rsum_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;

  logic [1:0]        ch_sel;
  logic [7:0]        mul_s;
  logic [5:0]        mul_v;
  logic signed [13:0] s_ext;
  logic signed [13:0] v_ext;
  logic signed [13:0] prod;
  logic [14:0]       prod_ext;

  // Shared multiplier: channel operands selected by the current FSM state.
  always_comb begin
    ch_sel = 2'd0;
    case (state_q)
      CH1:     ch_sel = 2'd1;
      CH2:     ch_sel = 2'd2;
      CH3:     ch_sel = 2'd3;
      default: ch_sel = 2'd0;
    endcase
    mul_s    = smp_q[ch_sel];
    mul_v    = vol_q[ch_sel][6] ? 6'h3F : vol_q[ch_sel][5:0];
    s_ext    = {{6{mul_s[7]}}, mul_s};
    v_ext    = {8'b0, mul_v};
    prod     = s_ext * v_ext;
    prod_ext = {prod[13], prod};
  end

  // Next-state, snapshot, accumulate and publish logic.
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    vol_d   = vol_q;
    lacc_d  = lacc_q;
    racc_d  = racc_q;
    lsum_d  = lsum_q;
    rsum_d  = rsum_q;
    valid_d = 1'b0;
    ovr_d   = clk7_en && sample_strb && (state_q != IDLE);
    if (clk7_en) begin
      case (state_q)
        IDLE: begin
          if (sample_strb) begin
            smp_d   = {sample3, sample2, sample1, sample0};
            vol_d   = {vol3, vol2, vol1, vol0};
            lacc_d  = '0;
            racc_d  = '0;
            state_d = CH0;
          end
        end
        CH0: begin
          racc_d  = racc_q + prod_ext;
          state_d = CH1;
        end
        CH1: begin
          lacc_d  = lacc_q + prod_ext;
          state_d = CH2;
        end
        CH2: begin
          lacc_d  = lacc_q + prod_ext;
          state_d = CH3;
        end
        CH3: begin
          racc_d  = racc_q + prod_ext;
          state_d = DONE;
        end
        DONE: begin
          lsum_d  = lacc_q;
          rsum_d  = racc_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      smp_q   <= '0;
      vol_q   <= '0;
      lacc_q  <= '0;
      racc_q  <= '0;
      lsum_q  <= '0;
      rsum_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      vol_q   <= vol_d;
      lacc_q  <= lacc_d;
      racc_q  <= racc_d;
      lsum_q  <= lsum_d;
      rsum_q  <= rsum_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ldatasum  = lsum_q;
  assign rdatasum  = rsum_q;
  assign sum_valid = valid_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_paula_audio_mix_sequencer.sv
// Self-checking bench for paula_audio_mix_sequencer: expected mixes are
// pushed to a queue at each accepted strobe and popped on sum_valid.
module tb_paula_audio_mix_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk7_en;
  logic        sample_strb;
  logic [7:0]  sample0, sample1, sample2, sample3;
  logic [6:0]  vol0, vol1, vol2, vol3;
  logic [14:0] ldatasum, rdatasum;
  logic        sum_valid, busy, overrun;

  int checks   = 0;
  int failures = 0;
  int ov_cnt   = 0;
  int sv_cnt   = 0;
  int edges    = 0;
  logic [29:0] exp_q[$];

  paula_audio_mix_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .clk7_en    (clk7_en),
    .sample_strb(sample_strb),
    .sample0    (sample0),
    .sample1    (sample1),
    .sample2    (sample2),
    .sample3    (sample3),
    .vol0       (vol0),
    .vol1       (vol1),
    .vol2       (vol2),
    .vol3       (vol3),
    .ldatasum   (ldatasum),
    .rdatasum   (rdatasum),
    .sum_valid  (sum_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout need finish");
    $fatal(1);
  end

  function automatic int chv(input logic [7:0] s, input logic [6:0] v);
    int ev;
    int si;
    ev = v[6] ? 63 : int'(v[5:0]);
    si = int'($signed(s));
    return si * ev;
  endfunction

  function automatic logic [29:0] model();
    int l;
    int r;
    l = chv(sample1, vol1) + chv(sample2, vol2);
    r = chv(sample0, vol0) + chv(sample3, vol3);
    return {15'(l), 15'(r)};
  endfunction

  task automatic randomize_inputs();
    sample0 = 8'($urandom); sample1 = 8'($urandom);
    sample2 = 8'($urandom); sample3 = 8'($urandom);
    vol0 = 7'($urandom); vol1 = 7'($urandom);
    vol2 = 7'($urandom); vol3 = 7'($urandom);
  endtask

  task automatic step(input logic en, input logic strb);
    logic [29:0] e;
    clk7_en = en;
    sample_strb = strb;
    @(posedge clk);
    @(negedge clk);
    if (en) edges++;
    if (overrun) ov_cnt++;
    if (sum_valid) begin
      sv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_sum_valid got l=%h r=%h need no pulse", ldatasum, rdatasum);
      end else begin
        e = exp_q.pop_front();
        if ({ldatasum, rdatasum} !== e) begin
          failures++;
          $display("FAIL mix_result got l=%h r=%h need l=%h r=%h",
                   ldatasum, rdatasum, e[29:15], e[14:0]);
        end
      end
    end
    clk7_en = 1'b0;
    sample_strb = 1'b0;
  endtask

  task automatic strobe_mix();
    exp_q.push_back(model());
    step(1'b1, 1'b1);
    edges = 0;
  endtask

  task automatic wait_valid(output int lat);
    int start;
    start = sv_cnt;
    for (int i = 0; i < 20 && sv_cnt == start; i++) step(1'b1, 1'b0);
    lat = edges;
    if (sv_cnt == start) begin
      checks++;
      failures++;
      $display("FAIL wait_valid got no pulse need sum_valid within 20 edges");
    end
  endtask

  task automatic check_latency(input string name, input int lat);
    checks++;
    if (lat !== 5) begin
      failures++;
      $display("FAIL %s_latency got %0d need 5", name, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; clk7_en = 1'b0; sample_strb = 1'b0;
    sample0 = '0; sample1 = '0; sample2 = '0; sample3 = '0;
    vol0 = '0; vol1 = '0; vol2 = '0; vol3 = '0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ldatasum !== 15'h0) begin failures++; $display("FAIL reset_ldatasum got %h need 0", ldatasum); end
    checks++; if (rdatasum !== 15'h0) begin failures++; $display("FAIL reset_rdatasum got %h need 0", rdatasum); end
    checks++; if (sum_valid !== 1'b0) begin failures++; $display("FAIL reset_sum_valid got %b need 0", sum_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b need 0", busy); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got %b need 0", overrun); end
    reset = 1'b0;
    step(1'b0, 1'b0);
  endtask

  task automatic test_mix();
    int lat;
    sample0 = 8'h40; vol0 = 7'h40;
    sample3 = 8'h80; vol3 = 7'h20;
    sample1 = 8'h7F; vol1 = 7'h3F;
    sample2 = 8'h7F; vol2 = 7'h7F;
    strobe_mix();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mix_busy got %b need 1", busy); end
    wait_valid(lat);
    check_latency("mix", lat);
    checks++; if (rdatasum !== 15'h7FC0) begin failures++; $display("FAIL mix_rdatasum got %h need 7fc0", rdatasum); end
    checks++; if (ldatasum !== 15'h3E82) begin failures++; $display("FAIL mix_ldatasum got %h need 3e82", ldatasum); end
    step(1'b0, 1'b0);
    checks++; if (sum_valid !== 1'b0) begin failures++; $display("FAIL mix_pulse_width got %b need 0", sum_valid); end
    step(1'b1, 1'b0);
    checks++; if (ldatasum !== 15'h3E82) begin failures++; $display("FAIL mix_hold got %h need 3e82", ldatasum); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mix_idle_busy got %b need 0", busy); end
  endtask

  task automatic test_extremes();
    int lat;
    sample0 = 8'h80; sample1 = 8'h80; sample2 = 8'h80; sample3 = 8'h80;
    vol0 = 7'h7F; vol1 = 7'h7F; vol2 = 7'h7F; vol3 = 7'h7F;
    strobe_mix();
    wait_valid(lat);
    checks++; if (ldatasum !== 15'h4100) begin failures++; $display("FAIL min_ldatasum got %h need 4100", ldatasum); end
    checks++; if (rdatasum !== 15'h4100) begin failures++; $display("FAIL min_rdatasum got %h need 4100", rdatasum); end
    sample0 = 8'h7F; sample1 = 8'h7F; sample2 = 8'h7F; sample3 = 8'h7F;
    vol0 = 7'h00; vol1 = 7'h00; vol2 = 7'h00; vol3 = 7'h00;
    strobe_mix();
    wait_valid(lat);
    checks++; if (ldatasum !== 15'h0) begin failures++; $display("FAIL zero_vol_ldatasum got %h need 0", ldatasum); end
    checks++; if (rdatasum !== 15'h0) begin failures++; $display("FAIL zero_vol_rdatasum got %h need 0", rdatasum); end
  endtask

  task automatic test_snapshot();
    int lat;
    for (int n = 0; n < 3; n++) begin
      randomize_inputs();
      strobe_mix();
      randomize_inputs();
      step(1'b1, 1'b0);
      randomize_inputs();
      wait_valid(lat);
      check_latency("snapshot", lat);
    end
  endtask

  task automatic test_overrun();
    int lat;
    int ov0;
    randomize_inputs();
    strobe_mix();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    ov0 = ov_cnt;
    randomize_inputs();
    step(1'b1, 1'b1);
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_pulse got %b need 1", overrun); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL overrun_busy got %b need 1", busy); end
    step(1'b0, 1'b1);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_width got %b need 0", overrun); end
    checks++; if (ov_cnt !== ov0 + 1) begin failures++; $display("FAIL overrun_gated_strobe got %0d need %0d", ov_cnt, ov0 + 1); end
    wait_valid(lat);
    check_latency("overrun", lat);
    randomize_inputs();
    strobe_mix();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL after_done_accept got busy=%b need 1", busy); end
    wait_valid(lat);
    check_latency("after_done", lat);
    checks++; if (ov_cnt !== ov0 + 1) begin failures++; $display("FAIL after_done_overrun got %0d need %0d", ov_cnt, ov0 + 1); end
  endtask

  task automatic test_gating();
    int lat;
    int sv0;
    randomize_inputs();
    strobe_mix();
    step(1'b1, 1'b0);
    sv0 = sv_cnt;
    repeat (3) step(1'b0, 1'b0);
    checks++; if (busy !== 1'b1 || sv_cnt !== sv0) begin failures++; $display("FAIL gating_frozen got busy=%b pulses=%0d need busy=1 pulses=%0d", busy, sv_cnt, sv0); end
    wait_valid(lat);
    check_latency("gating", lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    int sv0;
    randomize_inputs();
    strobe_mix();
    step(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    checks++; if (ldatasum !== 15'h0 || rdatasum !== 15'h0) begin failures++; $display("FAIL reset_mid_sums got l=%h r=%h need 0 0", ldatasum, rdatasum); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_mid_busy got %b need 0", busy); end
    exp_q.delete();
    sv0 = sv_cnt;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    reset = 1'b0;
    repeat (8) step(1'b1, 1'b0);
    checks++; if (sv_cnt !== sv0) begin failures++; $display("FAIL reset_mid_no_valid got %0d pulses need %0d", sv_cnt, sv0); end
    randomize_inputs();
    strobe_mix();
    wait_valid(lat);
    check_latency("reset_restart", lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int n = 0; n < 6; n++) begin
      randomize_inputs();
      strobe_mix();
      wait_valid(lat);
      check_latency("b2b", lat);
    end
  endtask

  initial begin
    test_reset();
    test_mix();
    test_extremes();
    test_snapshot();
    test_overrun();
    test_gating();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending need 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
